led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_led_seq_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED sequencer: shift / bounce / blink patterns stepped by a prescaled tick.
// Optional LED_SEQ_PWM_EN macro adds a 3-bit PWM duty gate (sw[7:5]) on ledr.
module led_seq_ctrl #(
  parameter int TICK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  output logic [15:0] ledr,
  output logic [1:0]  mode_o,
  output logic        step_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SHIFT    = 3'd1,
    ST_BOUNCE_L = 3'd2,
    ST_BOUNCE_R = 3'd3,
    ST_BLINK    = 3'd4
  } state_t;

`ifdef LED_SEQ_PWM_EN
  logic [7:0]    sw_q;
  logic [2:0]    pwm_cnt_q;
`else
  logic [4:0]    sw_q;
  logic          unused_duty;
  assign unused_duty = ^sw[7:5];
`endif

  state_t        state_q, state_d;
  logic [15:0]   pattern_q, pattern_d;
  logic [15:0]   ledr_q, ledr_d;
  logic [PW-1:0] presc_q;
  logic [2:0]    step_cnt_q;
  logic [1:0]    mode_q;
  logic          step_pend_q;
  logic          step_q;

  logic          reload;
  logic          tick;
  logic          step_hit;
  logic [2:0]    term;

  assign reload   = (sw_q[1:0] != mode_q);
  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign step_hit = !reload && tick && (step_cnt_q == term);

  always_comb begin
    case (sw_q[4:3])
      2'd0:    term = 3'd0;
      2'd1:    term = 3'd1;
      2'd2:    term = 3'd3;
      default: term = 3'd7;
    endcase
  end

  // Next pattern/state: reload on a mode change takes precedence over stepping.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    if (reload) begin
      case (sw_q[1:0])
        2'b00:   begin state_d = ST_OFF;      pattern_d = 16'h0000; end
        2'b01:   begin state_d = ST_SHIFT;    pattern_d = 16'h0001; end
        2'b10:   begin state_d = ST_BOUNCE_L; pattern_d = 16'h0001; end
        default: begin state_d = ST_BLINK;    pattern_d = 16'hFFFF; end
      endcase
    end else if (step_hit) begin
      case (state_q)
        ST_SHIFT: begin
          if (sw_q[2]) pattern_d = {pattern_q[0], pattern_q[15:1]};
          else         pattern_d = {pattern_q[14:0], pattern_q[15]};
        end
        ST_BOUNCE_L: begin
          if (pattern_q == 16'h8000) begin
            pattern_d = 16'h4000;
            state_d   = ST_BOUNCE_R;
          end else begin
            pattern_d = {pattern_q[14:0], 1'b0};
          end
        end
        ST_BOUNCE_R: begin
          if (pattern_q == 16'h0001) begin
            pattern_d = 16'h0002;
            state_d   = ST_BOUNCE_L;
          end else begin
            pattern_d = {1'b0, pattern_q[15:1]};
          end
        end
        ST_BLINK: pattern_d = ~pattern_q;
        default:  pattern_d = 16'h0000;
      endcase
    end else begin
      pattern_d = pattern_q;
    end
  end

`ifdef LED_SEQ_PWM_EN
  assign ledr_d = (pwm_cnt_q <= sw_q[7:5]) ? pattern_q : 16'h0000;
`else
  assign ledr_d = pattern_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q        <= '0;
      state_q     <= ST_OFF;
      pattern_q   <= 16'h0000;
      ledr_q      <= 16'h0000;
      presc_q     <= '0;
      step_cnt_q  <= 3'd0;
      mode_q      <= 2'b00;
      step_pend_q <= 1'b0;
      step_q      <= 1'b0;
`ifdef LED_SEQ_PWM_EN
      pwm_cnt_q   <= 3'd0;
`endif
    end else begin
`ifdef LED_SEQ_PWM_EN
      sw_q        <= sw;
      pwm_cnt_q   <= pwm_cnt_q + 3'd1;
`else
      sw_q        <= sw[4:0];
`endif
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      ledr_q      <= ledr_d;
      // step_o is delayed to line up with ledr, which trails pattern by one edge
      step_pend_q <= step_hit;
      step_q      <= step_pend_q;
      if (reload) begin
        presc_q    <= '0;
        step_cnt_q <= 3'd0;
        mode_q     <= sw_q[1:0];
      end else begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          step_cnt_q <= (step_cnt_q == term) ? 3'd0 : step_cnt_q + 3'd1;
        end
      end
    end
  end

  assign ledr   = ledr_q;
  assign mode_o = mode_q;
  assign step_o = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl with TICK_DIV=4.
module tb_led_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  sw;
  logic [15:0] ledr;
  logic [1:0]  mode_o;
  logic        step_o;

  int errors = 0;
  int checks = 0;

  led_seq_ctrl #(.TICK_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .ledr   (ledr),
    .mode_o (mode_o),
    .step_o (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land on the following falling edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] pat;
    logic        left;
    int          on_cnt;

    rst = 1'b1;
    sw  = 8'hE1;
    adv(3);
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_mode", 32'(mode_o), 32'h0);
    chk("rst_step", 32'(step_o), 32'h0);

    rst = 1'b0;
    adv(2);
    chk("rel_ledr_early", 32'(ledr), 32'h0);
    adv(1);
    chk("rel_ledr", 32'(ledr), 32'h0001);
    chk("rel_mode", 32'(mode_o), 32'h1);
    chk("rel_step_idle", 32'(step_o), 32'h0);

    // SHIFT left, one step every 4 clk, full rotation
    for (int k = 1; k <= 16; k++) begin
      adv(4);
      pat = 16'h0001 << (k % 16);
      chk($sformatf("shl_%0d", k), 32'(ledr), 32'(pat));
      chk($sformatf("shl_step_%0d", k), 32'(step_o), 32'h1);
    end
    adv(1);
    chk("shl_step_low", 32'(step_o), 32'h0);
    adv(3);
    chk("shl_17", 32'(ledr), 32'h0002);

    sw = 8'hE5;
    adv(4);
    chk("shr_1", 32'(ledr), 32'h0001);
    adv(4);
    chk("shr_2", 32'(ledr), 32'h8000);
    adv(4);
    chk("shr_3", 32'(ledr), 32'h4000);

    // SHIFT -> BLINK mid-prescale
    adv(1);
    sw = 8'hE3;
    adv(2);
    chk("blk_lat2", 32'(ledr), 32'h4000);
    adv(1);
    chk("blk_entry", 32'(ledr), 32'hFFFF);
    chk("blk_mode", 32'(mode_o), 32'h3);
    adv(4);
    chk("blk_tog1", 32'(ledr), 32'h0000);
    chk("blk_tog1_step", 32'(step_o), 32'h1);

    sw = 8'hE0;
    adv(3);
    chk("off_ledr", 32'(ledr), 32'h0000);
    chk("off_mode", 32'(mode_o), 32'h0);
    adv(4);
    chk("off_step", 32'(step_o), 32'h1);
    chk("off_hold", 32'(ledr), 32'h0000);

    // BLINK at speed 11: toggle every 32 clk
    sw = 8'hFB;
    adv(3);
    chk("blk8_entry", 32'(ledr), 32'hFFFF);
    adv(32);
    chk("blk8_t1", 32'(ledr), 32'h0000);
    chk("blk8_t1_step", 32'(step_o), 32'h1);
    adv(31);
    chk("blk8_hold", 32'(ledr), 32'h0000);
    chk("blk8_hold_step", 32'(step_o), 32'h0);
    adv(1);
    chk("blk8_t2", 32'(ledr), 32'hFFFF);

    // BOUNCE, 30 steps per period
    sw = 8'hE2;
    adv(3);
    chk("bnc_entry", 32'(ledr), 32'h0001);
    chk("bnc_mode", 32'(mode_o), 32'h2);
    pat  = 16'h0001;
    left = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      if (left) begin
        if (pat == 16'h8000) begin pat = 16'h4000; left = 1'b0; end
        else pat = pat << 1;
      end else begin
        if (pat == 16'h0001) begin pat = 16'h0002; left = 1'b1; end
        else pat = pat >> 1;
      end
      adv(4);
      if (k == 15 || k == 16 || k == 30 || k == 31 || k == 48)
        chk($sformatf("bnc_%0d", k), 32'(ledr), 32'(pat));
    end
    chk("bnc_p30_model", 32'(pat), 32'h1000);

    // Reset while bouncing right, mid-prescale
    adv(1);
    rst = 1'b1;
    adv(1);
    chk("rstmid_ledr", 32'(ledr), 32'h0);
    chk("rstmid_mode", 32'(mode_o), 32'h0);
    chk("rstmid_step", 32'(step_o), 32'h0);

    // Duty field: gated with PWM, ignored without
    rst = 1'b0;
    sw  = 8'h61;
    adv(3);
    on_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (ledr != 16'h0000) on_cnt++;
      adv(1);
    end
`ifdef LED_SEQ_PWM_EN
    chk("duty3_on", 32'(on_cnt), 32'd4);
`else
    chk("duty_ignored_on", 32'(on_cnt), 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
